// File: rtl/format_decode_stage.sv
// Decode stage 1: classifies each lane's primary opcode into a one-hot-OR
// format mask and carries the fetch group through a 2-entry skid buffer
// with valid/ready flow control, flush, per-lane illegal flags and a
// saturating illegal-lane counter.
module format_decode_stage #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned PID_W  = 20,
  parameter int unsigned TID_W  = 16,
  parameter int unsigned ID_W   = 64,
  parameter int unsigned FMT_W  = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [LANES-1:0]        laneValid_i,
  input  logic [LANES*INST_W-1:0] instruction_i,
  input  logic [ADDR_W-1:0]       instructionAddress_i,
  input  logic [PID_W-1:0]        instructionPid_i,
  input  logic [TID_W-1:0]        instructionTid_i,
  input  logic [ID_W-1:0]         instructionMajId_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [LANES-1:0]        laneValid_o,
  output logic [LANES*FMT_W-1:0]  instFormat_o,
  output logic [LANES-1:0]        illegal_o,
  output logic [LANES*INST_W-1:0] instruction_o,
  output logic [LANES*ADDR_W-1:0] instructionAddress_o,
  output logic [PID_W-1:0]        instructionPid_o,
  output logic [TID_W-1:0]        instructionTid_o,
  output logic [LANES*ID_W-1:0]   instructionMajId_o,
  output logic [CNT_W-1:0]        illegalCount_o
);

  // Format mask bit positions
  localparam int unsigned F_I    = 0;
  localparam int unsigned F_B    = 1;
  localparam int unsigned F_XL   = 2;
  localparam int unsigned F_DX   = 3;
  localparam int unsigned F_SC   = 4;
  localparam int unsigned F_D    = 5;
  localparam int unsigned F_X    = 6;
  localparam int unsigned F_XO   = 7;
  localparam int unsigned F_Z23  = 8;
  localparam int unsigned F_A    = 9;
  localparam int unsigned F_XS   = 10;
  localparam int unsigned F_XFX  = 11;
  localparam int unsigned F_DS   = 12;
  localparam int unsigned F_DQ   = 13;
  localparam int unsigned F_VA   = 14;
  localparam int unsigned F_VX   = 15;
  localparam int unsigned F_VC   = 16;
  localparam int unsigned F_M    = 17;
  localparam int unsigned F_MD   = 18;
  localparam int unsigned F_MDS  = 19;
  localparam int unsigned F_XFL  = 20;
  localparam int unsigned F_Z22  = 21;
  localparam int unsigned F_XX2  = 22;
  localparam int unsigned F_XX3  = 23;

  localparam int unsigned SUM_W = CNT_W + $clog2(LANES + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef struct packed {
    logic [LANES-1:0]        lane_valid;
    logic [LANES*FMT_W-1:0]  fmt;
    logic [LANES-1:0]        illegal;
    logic [LANES*INST_W-1:0] inst;
    logic [LANES*ADDR_W-1:0] addr;
    logic [PID_W-1:0]        pid;
    logic [TID_W-1:0]        tid;
    logic [LANES*ID_W-1:0]   id;
  } group_t;

  // Primary opcode to format mask; an all-zero mask marks an illegal opcode
  function automatic logic [FMT_W-1:0] classify(input logic [5:0] op);
    logic [FMT_W-1:0] m;
    m = '0;
    case (op) inside
      6'd18: m[F_I] = 1'b1;
      6'd16: m[F_B] = 1'b1;
      6'd19: begin m[F_XL] = 1'b1; m[F_DX] = 1'b1; end
      6'd17: m[F_SC] = 1'b1;
      6'd31: begin
        m[F_X]  = 1'b1; m[F_XO] = 1'b1; m[F_Z23] = 1'b1;
        m[F_A]  = 1'b1; m[F_XS] = 1'b1; m[F_XFX] = 1'b1;
      end
      6'd4: begin m[F_VA] = 1'b1; m[F_VX] = 1'b1; m[F_VC] = 1'b1; end
      6'd20, 6'd21, 6'd23: m[F_M] = 1'b1;
      6'd30: begin m[F_MD] = 1'b1; m[F_MDS] = 1'b1; end
      6'd56: m[F_DQ] = 1'b1;
      6'd57, 6'd58, 6'd61, 6'd62: m[F_DS] = 1'b1;
      6'd59: begin
        m[F_A] = 1'b1; m[F_X] = 1'b1; m[F_Z22] = 1'b1; m[F_Z23] = 1'b1;
      end
      6'd60: begin m[F_XX2] = 1'b1; m[F_XX3] = 1'b1; end
      6'd63: begin
        m[F_A]   = 1'b1; m[F_X]   = 1'b1; m[F_XFL] = 1'b1;
        m[F_Z22] = 1'b1; m[F_Z23] = 1'b1;
      end
      6'd2, 6'd3, 6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29], [6'd32:6'd55]:
        m[F_D] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  group_t            incoming;
  group_t            main_q;
  group_t            skid_q;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              consume;
  logic [INST_W-1:0] lane_inst;
  logic [FMT_W-1:0]  lane_fmt;
  logic [SUM_W-1:0]  illegal_add;
  logic [SUM_W-1:0]  count_sum;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;

  assign ready_o = ~skid_valid;
  assign valid_o = main_valid;
  assign accept  = valid_i & ready_o;
  assign consume = main_valid & ready_i;

  // Classify the group at the input and derive per-lane address / major ID
  always_comb begin
    incoming     = '0;
    lane_inst    = '0;
    lane_fmt     = '0;
    incoming.pid = instructionPid_i;
    incoming.tid = instructionTid_i;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_inst = instruction_i[k*INST_W +: INST_W];
      lane_fmt  = classify(lane_inst[INST_W-1 -: 6]);
      incoming.inst[k*INST_W +: INST_W] = lane_inst;
      incoming.addr[k*ADDR_W +: ADDR_W] = instructionAddress_i + ADDR_W'(4 * k);
      incoming.id[k*ID_W +: ID_W]       = instructionMajId_i + ID_W'(k);
      incoming.lane_valid[k]            = laneValid_i[k];
      if (laneValid_i[k]) begin
        incoming.fmt[k*FMT_W +: FMT_W] = lane_fmt;
        incoming.illegal[k]            = (lane_fmt == '0);
      end
    end
  end

  // Saturating sum of the counter and this group's illegal lanes
  always_comb begin
    illegal_add = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      illegal_add = illegal_add + SUM_W'(incoming.illegal[k]);
    end
    count_sum  = SUM_W'(count_q) + illegal_add;
    count_next = (count_sum > CNT_MAX) ? '1 : count_sum[CNT_W-1:0];
  end

  // Main/skid occupancy and data movement; skid always drains into main first
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      count_q    <= '0;
    end else if (flush_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= count_next;
      end
      if (consume) begin
        // accept cannot coincide with a full skid, so skid->main never loses a group
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_q <= incoming;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_q     <= incoming;
          skid_valid <= 1'b1;
        end else begin
          main_q     <= incoming;
          main_valid <= 1'b1;
        end
      end
    end
  end

  assign laneValid_o          = main_q.lane_valid;
  assign instFormat_o         = main_q.fmt;
  assign illegal_o            = main_q.illegal;
  assign instruction_o        = main_q.inst;
  assign instructionAddress_o = main_q.addr;
  assign instructionPid_o     = main_q.pid;
  assign instructionTid_o     = main_q.tid;
  assign instructionMajId_o   = main_q.id;
  assign illegalCount_o       = count_q;

endmodule

// File: tb/tb_format_decode_stage.sv
// Directed bench for format_decode_stage: handshake, skid ordering, flush,
// illegal flagging, counter saturation and the full opcode table.
module tb_format_decode_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         valid_in;
  logic         ready_out;
  logic [1:0]   lane_valid_in;
  logic [63:0]  instr_in;
  logic [63:0]  addr_in;
  logic [19:0]  pid_in;
  logic [15:0]  tid_in;
  logic [63:0]  id_in;
  logic         valid_out;
  logic         ready_in;
  logic [1:0]   lane_valid_out;
  logic [47:0]  fmt_out;
  logic [1:0]   illegal_out;
  logic [63:0]  instr_out;
  logic [127:0] addr_out;
  logic [19:0]  pid_out;
  logic [15:0]  tid_out;
  logic [127:0] id_out;
  logic [15:0]  count_out;

  logic         ready_out2;
  logic         valid_out2;
  logic [1:0]   lane_valid_out2;
  logic [47:0]  fmt_out2;
  logic [1:0]   illegal_out2;
  logic [63:0]  instr_out2;
  logic [127:0] addr_out2;
  logic [19:0]  pid_out2;
  logic [15:0]  tid_out2;
  logic [127:0] id_out2;
  logic [1:0]   count_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  format_decode_stage dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush),
    .valid_i(valid_in), .ready_o(ready_out),
    .laneValid_i(lane_valid_in), .instruction_i(instr_in),
    .instructionAddress_i(addr_in), .instructionPid_i(pid_in),
    .instructionTid_i(tid_in), .instructionMajId_i(id_in),
    .valid_o(valid_out), .ready_i(ready_in),
    .laneValid_o(lane_valid_out), .instFormat_o(fmt_out),
    .illegal_o(illegal_out), .instruction_o(instr_out),
    .instructionAddress_o(addr_out), .instructionPid_o(pid_out),
    .instructionTid_o(tid_out), .instructionMajId_o(id_out),
    .illegalCount_o(count_out)
  );

  format_decode_stage #(.CNT_W(2)) dut_small (
    .clock_i(clk), .reset_i(rst), .flush_i(flush),
    .valid_i(valid_in), .ready_o(ready_out2),
    .laneValid_i(lane_valid_in), .instruction_i(instr_in),
    .instructionAddress_i(addr_in), .instructionPid_i(pid_in),
    .instructionTid_i(tid_in), .instructionMajId_i(id_in),
    .valid_o(valid_out2), .ready_i(ready_in),
    .laneValid_o(lane_valid_out2), .instFormat_o(fmt_out2),
    .illegal_o(illegal_out2), .instruction_o(instr_out2),
    .instructionAddress_o(addr_out2), .instructionPid_o(pid_out2),
    .instructionTid_o(tid_out2), .instructionMajId_o(id_out2),
    .illegalCount_o(count_out2)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed format masks for every primary opcode
  function automatic logic [23:0] exp_fmt(input int unsigned op);
    case (op)
      18: return 24'h000001;
      16: return 24'h000002;
      19: return 24'h00000C;
      17: return 24'h000010;
      31: return 24'h000FC0;
      4:  return 24'h01C000;
      20, 21, 23: return 24'h020000;
      30: return 24'h0C0000;
      56: return 24'h002000;
      57, 58, 61, 62: return 24'h001000;
      59: return 24'h200340;
      60: return 24'hC00000;
      63: return 24'h300340;
      0, 1, 5, 6, 9, 22: return 24'h000000;
      default: return 24'h000020;
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    lane_valid_in = 2'b00; instr_in = '0; addr_in = '0;
    pid_in = '0; tid_in = '0; id_in = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 256'(valid_out), 256'(0));
    check("rst_ready", 256'(ready_out), 256'(1));
    check("rst_fmt", 256'(fmt_out), 256'(0));
    check("rst_count", 256'(count_out), 256'(0));

    // single group, one cycle latency
    valid_in = 1'b1; ready_in = 1'b1; lane_valid_in = 2'b11;
    instr_in = {32'h7C000000, 32'h48000000};
    addr_in = 64'h100; id_in = 64'd7; pid_in = 20'hABCDE; tid_in = 16'h1234;
    step();
    valid_in = 1'b0;
    check("t1_valid", 256'(valid_out), 256'(1));
    check("t1_fmt", 256'(fmt_out), 256'({24'h000FC0, 24'h000001}));
    check("t1_addr", 256'(addr_out), 256'({64'h104, 64'h100}));
    check("t1_id", 256'(id_out), 256'({64'd8, 64'd7}));
    check("t1_illegal", 256'(illegal_out), 256'(0));
    check("t1_pid", 256'(pid_out), 256'(20'hABCDE));
    check("t1_tid", 256'(tid_out), 256'(16'h1234));
    check("t1_instr", 256'(instr_out), 256'({32'h7C000000, 32'h48000000}));
    step();
    check("t1_drained", 256'(valid_out), 256'(0));

    // backpressure: two groups fill main+skid, third waits
    ready_in = 1'b0; valid_in = 1'b1;
    instr_in = {32'h40000000, 32'h38000000};
    addr_in = 64'h200; id_in = 64'h10;
    step();
    check("t2_g1_valid", 256'(valid_out), 256'(1));
    check("t2_g1_ready", 256'(ready_out), 256'(1));
    check("t2_g1_fmt", 256'(fmt_out), 256'({24'h000002, 24'h000020}));
    addr_in = 64'h300; id_in = 64'h20;
    step();
    check("t2_full_ready", 256'(ready_out), 256'(0));
    check("t2_hold_addr", 256'(addr_out), 256'({64'h204, 64'h200}));
    addr_in = 64'h400; id_in = 64'h30;
    step();
    check("t2_stall_ready", 256'(ready_out), 256'(0));
    check("t2_stall_addr", 256'(addr_out), 256'({64'h204, 64'h200}));
    check("t2_stall_id", 256'(id_out), 256'({64'h11, 64'h10}));
    ready_in = 1'b1;
    step();
    check("t2_g2_valid", 256'(valid_out), 256'(1));
    check("t2_g2_addr", 256'(addr_out), 256'({64'h304, 64'h300}));
    check("t2_g2_ready", 256'(ready_out), 256'(1));
    step();
    valid_in = 1'b0;
    check("t2_g3_valid", 256'(valid_out), 256'(1));
    check("t2_g3_addr", 256'(addr_out), 256'({64'h404, 64'h400}));
    check("t2_g3_id", 256'(id_out), 256'({64'h31, 64'h30}));
    step();
    check("t2_end_valid", 256'(valid_out), 256'(0));

    // illegal opcode flagging and masked lanes
    valid_in = 1'b1; lane_valid_in = 2'b11;
    instr_in = {32'h48000000, 32'h00000000};
    step();
    check("t3_illegal", 256'(illegal_out), 256'(2'b01));
    check("t3_fmt", 256'(fmt_out), 256'({24'h000001, 24'h000000}));
    check("t3_count", 256'(count_out), 256'(1));
    lane_valid_in = 2'b01;
    instr_in = {32'h04000000, 32'h00000000};
    step();
    valid_in = 1'b0;
    check("t3_mask_illegal", 256'(illegal_out), 256'(2'b01));
    check("t3_mask_lanes", 256'(lane_valid_out), 256'(2'b01));
    check("t3_mask_fmt", 256'(fmt_out), 256'(0));
    check("t3_count2", 256'(count_out), 256'(2));
    step();

    // flush with both entries full and a group on the input
    ready_in = 1'b0; valid_in = 1'b1; lane_valid_in = 2'b11;
    instr_in = {32'h48000000, 32'h48000000}; addr_in = 64'h500;
    step();
    addr_in = 64'h600;
    step();
    check("t4_full", 256'(ready_out), 256'(0));
    addr_in = 64'h700; flush = 1'b1;
    step();
    flush = 1'b0; valid_in = 1'b0;
    check("t4_flush_valid", 256'(valid_out), 256'(0));
    check("t4_flush_ready", 256'(ready_out), 256'(1));
    step();
    check("t4_not_captured", 256'(valid_out), 256'(0));
    valid_in = 1'b1; lane_valid_in = 2'b01; instr_in = '0; flush = 1'b1;
    step();
    flush = 1'b0; valid_in = 1'b0;
    check("t4_accept_ignored", 256'(valid_out), 256'(0));
    check("t4_count_kept", 256'(count_out), 256'(2));
    step();
    check("t4_still_empty", 256'(valid_out), 256'(0));

    // opcode sweep on lane 0, back-to-back groups
    ready_in = 1'b1; lane_valid_in = 2'b01;
    for (int unsigned op = 0; op < 64; op++) begin
      instr_in = {32'h0, op[5:0], 26'h0};
      valid_in = 1'b1;
      step();
      check($sformatf("t6_fmt_op%0d", op), 256'(fmt_out), 256'({24'h0, exp_fmt(op)}));
      check($sformatf("t6_ill_op%0d", op), 256'(illegal_out),
            256'({1'b0, exp_fmt(op) == 24'h0}));
    end
    valid_in = 1'b0;
    check("t6_count", 256'(count_out), 256'(8));
    step();

    // counter saturation on a 2-bit counter, then reset mid-stream
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid_in = 1'b1; ready_in = 1'b1; lane_valid_in = 2'b11;
    instr_in = {32'h00000123, 32'h00000123};
    addr_in = 64'h900; id_in = 64'h55; pid_in = 20'h1; tid_in = 16'h2;
    step();
    check("t5_cnt_a", 256'(count_out2), 256'(2));
    check("t5_wide_a", 256'(count_out), 256'(2));
    step();
    check("t5_cnt_sat", 256'(count_out2), 256'(3));
    lane_valid_in = 2'b01;
    step();
    check("t5_cnt_hold", 256'(count_out2), 256'(3));
    check("t5_wide_b", 256'(count_out), 256'(5));
    rst = 1'b1;
    step();
    rst = 1'b0; valid_in = 1'b0;
    check("t5_rst_valid", 256'(valid_out), 256'(0));
    check("t5_rst_ready", 256'(ready_out), 256'(1));
    check("t5_rst_fmt", 256'(fmt_out), 256'(0));
    check("t5_rst_illegal", 256'(illegal_out), 256'(0));
    check("t5_rst_lanes", 256'(lane_valid_out), 256'(0));
    check("t5_rst_instr", 256'(instr_out), 256'(0));
    check("t5_rst_addr", 256'(addr_out), 256'(0));
    check("t5_rst_id", 256'(id_out), 256'(0));
    check("t5_rst_pid", 256'(pid_out), 256'(0));
    check("t5_rst_count", 256'(count_out), 256'(0));
    check("t5_rst_count2", 256'(count_out2), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
